// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32 fetch stage: datapath width, PC step,
// bubble instruction and the fetch FSM encoding.
package fetch_stage_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC      = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_ALIGN    = 32'hFFFF_FFFC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter with enable and synchronous active-high reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= sat_inc(cnt_o);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC sequencing, taken-branch
// redirect with one-slot squash, load-use stall hold and perf counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C,
    parameter int              CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic [XLEN-1:0]  instr_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  if_id_pc_o,
    output logic [XLEN-1:0]  if_id_instr_o,
    output logic             if_id_valid_o,
    output logic             running_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    fetch_state_t    state_p0;
    logic            running_p0;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] if_id_pc_p1;
    logic [XLEN-1:0] if_id_instr_p1;
    logic            vld_p1;

    logic stall_evt;
    logic flush_evt;

    assign stall_evt = running_p0 && stall_i;
    assign flush_evt = running_p0 && !stall_i && branch_taken_i;

    // IF stage: PC register and fetch FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p0       <= IDLE;
            running_p0     <= 1'b0;
            pc_p0          <= RESET_PC;
            if_id_pc_p1    <= '0;
            if_id_instr_p1 <= NOP_INSTR;
            vld_p1         <= 1'b0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (start_i) begin
                        state_p0   <= RUN;
                        running_p0 <= 1'b1;
                    end
                end
                RUN: begin
                    // A stalled ID cannot trust its comparator, so the branch waits.
                    if (!stall_i) begin
                        if_id_pc_p1 <= pc_p0;
                        if (branch_taken_i) begin
                            pc_p0          <= branch_target_i & PC_ALIGN;
                            if_id_instr_p1 <= NOP_INSTR;
                            vld_p1         <= 1'b0;
                        end else begin
                            pc_p0          <= pc_p0 + PC_INC;
                            if_id_instr_p1 <= instr_i;
                            vld_p1         <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_p0   <= IDLE;
                    running_p0 <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID boundary outputs
    assign pc_o          = pc_p0;
    assign if_id_pc_o    = if_id_pc_p1;
    assign if_id_instr_o = if_id_instr_p1;
    assign if_id_valid_o = vld_p1;
    assign running_o     = running_p0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_evt),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (flush_evt),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected
// post-edge state, which is popped and compared one edge later.
module tb_fetch_stage;

    localparam int CW = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic [31:0]   branch_target_i = '0;
    logic [31:0]   instr_i;
    logic [31:0]   pc_o;
    logic [31:0]   if_id_pc_o;
    logic [31:0]   if_id_instr_o;
    logic          if_id_valid_o;
    logic          running_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    assign instr_i = imem(pc_o);

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .CNT_W     (CW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .instr_i         (instr_i),
        .pc_o            (pc_o),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o),
        .running_o       (running_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   ipc;
        logic [31:0]   instr;
        logic          vld;
        logic          run;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat_next(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Drive one cycle, push the model's expected post-edge state, then compare.
    task automatic step(input logic rst, input logic start, input logic stall,
                        input logic br, input logic [31:0] tgt);
        exp_t e;
        exp_t got;
        rst_i = rst; start_i = start; stall_i = stall;
        branch_taken_i = br; branch_target_i = tgt;
        e = m;
        if (rst) begin
            e.pc = 32'h0; e.ipc = 32'h0; e.instr = NOP; e.vld = 1'b0;
            e.run = 1'b0; e.sc = '0; e.fc = '0;
        end else if (!m.run) begin
            if (start) e.run = 1'b1;
        end else if (stall) begin
            e.sc = sat_next(m.sc);
        end else if (br) begin
            e.ipc = m.pc; e.pc = {tgt[31:2], 2'b00}; e.instr = NOP;
            e.vld = 1'b0; e.fc = sat_next(m.fc);
        end else begin
            e.ipc = m.pc; e.instr = imem(m.pc); e.pc = m.pc + 32'd4; e.vld = 1'b1;
        end
        sb.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val("pc",      pc_o,                  got.pc);
        check_val("if_id_pc", if_id_pc_o,           got.ipc);
        check_val("if_id_instr", if_id_instr_o,     got.instr);
        check_val("valid",   {31'b0, if_id_valid_o}, {31'b0, got.vld});
        check_val("running", {31'b0, running_o},     {31'b0, got.run});
        check_val("stall_cnt", 32'(stall_cnt_o),    32'(got.sc));
        check_val("flush_cnt", 32'(flush_cnt_o),    32'(got.fc));
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        m = '{pc: 32'h0, ipc: 32'h0, instr: NOP, vld: 1'b0, run: 1'b0, sc: '0, fc: '0};

        // Reset then start
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_val("rst_pc", pc_o, 32'h0);
        check_val("rst_instr", if_id_instr_o, NOP);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);  // IDLE ignores stall/branch
        check_val("idle_pc_hold", pc_o, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("run_entered", {31'b0, running_o}, 32'h1);
        idle_cycle();
        check_val("first_ipc", if_id_pc_o, 32'h0);
        check_val("first_instr", if_id_instr_o, imem(32'h0));
        check_val("first_valid", {31'b0, if_id_valid_o}, 32'h1);
        check_val("pc_4", pc_o, 32'h4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);  // start ignored in RUN
        check_val("pc_8", pc_o, 32'h8);
        idle_cycle();
        check_val("pc_12", pc_o, 32'hC);
        idle_cycle();

        // Taken branch at 0x10
        check_val("pc_10", pc_o, 32'h10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        check_val("br_pc", pc_o, 32'h40);
        check_val("br_nop", if_id_instr_o, NOP);
        check_val("br_valid", {31'b0, if_id_valid_o}, 32'h0);
        check_val("br_fcnt", 32'(flush_cnt_o), 32'h1);
        idle_cycle();
        check_val("br_ipc", if_id_pc_o, 32'h40);

        // Fresh run up to 0x20, then stall with branch for 3 cycles
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) idle_cycle();
        check_val("pc_20", pc_o, 32'h20);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
        check_val("stall_pc", pc_o, 32'h20);
        check_val("stall_ipc", if_id_pc_o, 32'h1C);
        check_val("stall_cnt3", 32'(stall_cnt_o), 32'h3);
        check_val("stall_fcnt0", 32'(flush_cnt_o), 32'h0);

        // Stall release with branch still asserted
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        check_val("release_pc", pc_o, 32'h80);

        // Wrap and alignment
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check_val("align_pc", pc_o, 32'hFFFF_FFFC);
        idle_cycle();
        check_val("wrap_pc", pc_o, 32'h0);
        check_val("wrap_ipc", if_id_pc_o, 32'hFFFF_FFFC);

        // Self-loop, taken twice back to back
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1, m.pc);
        check_val("selfloop_pc", pc_o, 32'h0);
        check_val("selfloop_fcnt", 32'(flush_cnt_o), 32'h4);

        // Saturation, then mid-run reset with branch asserted
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_val("stall_sat", 32'(stall_cnt_o), 32'hF);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        check_val("mrst_pc", pc_o, 32'h0);
        check_val("mrst_run", {31'b0, running_o}, 32'h0);
        check_val("mrst_scnt", 32'(stall_cnt_o), 32'h0);
        check_val("mrst_fcnt", 32'(flush_cnt_o), 32'h0);
        check_val("mrst_valid", {31'b0, if_id_valid_o}, 32'h0);
        idle_cycle();

        // Random run: mixed stalls and branches against the model
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32 pipeline.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched instruction into IF/ID.
- Consumes the ID-stage branch decision (branch-taken flag from the equality comparator AND Branch control) plus target address, redirects the PC and flushes the wrong-path instruction.
- Honours load-use stalls from the hazard unit and keeps stall/flush performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted into IF/ID on flush.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  begins fetching; sampled only in IDLE.
- stall_i  input  1  load-use stall from hazard detection; freezes PC and IF/ID.
- branch_taken_i  input  1  ID-stage branch resolved taken (comparator equal AND Branch).
- branch_target_i  input  32  branch target computed in ID.
- instr_i  input  32  instruction memory read data for pc_o (combinational, same cycle).
- pc_o  output  32  instruction memory address (current PC register).
- if_id_pc_o  output  32  PC of the instruction held in IF/ID.
- if_id_instr_o  output  32  instruction held in IF/ID.
- if_id_valid_o  output  1  IF/ID holds a real (non-bubble) instruction.
- running_o  output  1  high in RUN state.
- stall_cnt_o  output  CNT_W  number of stalled RUN cycles, saturating.
- flush_cnt_o  output  CNT_W  number of taken-branch flushes, saturating.

Behaviour:
- Reset (rst_i=1 at edge, overrides every other input, including mid-operation):
  - state=IDLE, pc=RESET_PC.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - both counters=0, running_o=0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when start_i=1. Otherwise stay.
  - RUN is sticky until reset; start_i is ignored in RUN.
- IDLE behaviour:
  - PC and IF/ID hold their values.
  - stall_i and branch_taken_i are ignored; counters do not count.
- RUN, per cycle, priority stall > branch > normal:
  - stall_i=1: pc, if_id_pc, if_id_instr and if_id_valid hold; stall_cnt++. branch_taken_i is ignored, because the comparator operands are not yet valid and ID re-evaluates next cycle.
  - stall_i=0, branch_taken_i=1: pc <= {branch_target_i[31:2],2'b00}; if_id_instr <= NOP_INSTR; if_id_pc <= pc; if_id_valid <= 0; flush_cnt++. Exactly one wrong-path instruction is squashed, giving a taken-branch penalty of 1 cycle.
  - Neither asserted: pc <= pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0); if_id_pc <= pc; if_id_instr <= instr_i; if_id_valid <= 1.
- Timing:
  - pc_o is a register output with zero combinational path from inputs.
  - Latency from the start_i edge to the first valid IF/ID instruction is 2 edges: edge 1 enters RUN, edge 2 captures instr_i at RESET_PC.
- Counters saturate at all-ones with no wrap.
- Consecutive taken branches each redirect and each increment flush_cnt.
- A branch target equal to the current PC (self-loop) is legal and repeats.
- branch_target_i bits [1:0] are ignored.

Decomposition:
- Shared pipeline package holds:
  - state enum (IDLE, RUN)
  - NOP_INSTR constant
  - XLEN=32 and the PC increment constant 4
- One sub-module: sat_counter (CNT_W-wide, enable, synchronous reset, saturating), instantiated twice for the stall and flush counters.
- The PC and IF/ID registers stay in fetch_stage.

Test Plan:
- Reset then start: rst_i=1 for 2 cycles, start_i pulse. Required response:
  - pc_o=0 in IDLE.
  - After 2 edges, if_id_pc_o=0, if_id_instr_o=mem[0], valid=1.
  - pc_o=4, 8, 12 on the following edges.
- Taken branch: at pc_o=0x10, assert branch_taken_i with target 0x40 for one cycle. Required response:
  - Next edge: pc_o=0x40, if_id_instr_o=0x00000013, valid=0, flush_cnt_o=1.
  - Following edge: if_id_pc_o=0x40.
- Stall with branch: stall_i=1 and branch_taken_i=1 together for 3 cycles at pc=0x20. Required response:
  - pc_o stays 0x20 and IF/ID stays unchanged.
  - stall_cnt_o=3, flush_cnt_o=0.
- Stall release: drop stall_i while keeping branch_taken_i=1 with target 0x80. Required response: next edge pc_o=0x80.
- Wrap and alignment:
  - Branch to 0xFFFFFFFF: pc_o=0xFFFFFFFC.
  - Next normal cycle: pc_o=0x00000000, if_id_pc_o=0xFFFFFFFC.
- Mid-run reset and saturation:
  - With CNT_W=4, hold stall_i for 20 cycles: stall_cnt_o=15.
  - Then assert rst_i one cycle in RUN with branch_taken_i=1: state returns to IDLE, pc_o=RESET_PC, counters=0, valid=0, and no redirect occurs.
